// File: rtl/if_fetch_unit_pkg.sv
// Shared IF-stage definitions: fetch FSM encoding, pipeline constants and
// the alignment helper used on redirect targets.
package if_fetch_unit_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: owns the PC, keeps at most one instruction-memory
// request in flight and drives the IF/ID register inputs.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        ifid_wr_en,
   output logic        ifid_flush,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc_next
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  hold_q, hold_d;
   logic         kill_q, kill_d;
   logic [31:0]  pc_inc;
   logic [31:0]  redirect_tgt;
   logic         deliver;
   logic [31:0]  deliver_word;

   assign pc_inc       = pc_q + PC_STEP;
   assign redirect_tgt = word_align(redirect_pc);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         kill_q  <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         kill_q  <= kill_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      kill_d  = kill_q;
      hold_d  = hold_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (redirect) pc_d = redirect_tgt;
            if (imem_req_ready) begin
               state_d = S_WAIT;
               // request already left with the old PC; its response is wrong-path
               if (redirect) kill_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid && (kill_q || redirect)) begin
               kill_d  = 1'b0;
               state_d = S_REQ;
               if (redirect) pc_d = redirect_tgt;
            end else if (redirect) begin
               pc_d   = redirect_tgt;
               kill_d = 1'b1;
            end else if (imem_rsp_valid) begin
               if (stall) begin
                  hold_d  = imem_rsp_data;
                  state_d = S_HOLD;
               end else begin
                  pc_d    = pc_inc;
                  state_d = S_REQ;
               end
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_d    = redirect_tgt;
               hold_d  = '0;
               state_d = S_REQ;
            end else if (!stall) begin
               pc_d    = pc_inc;
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      deliver      = 1'b0;
      deliver_word = NOP_INSTR;
      if (state_q == S_WAIT && imem_rsp_valid && !kill_q && !redirect && !stall) begin
         deliver      = 1'b1;
         deliver_word = imem_rsp_data;
      end else if (state_q == S_HOLD && !stall && !redirect) begin
         deliver      = 1'b1;
         deliver_word = hold_q;
      end

      imem_req_valid = (state_q == S_REQ);
      imem_addr      = (state_q == S_REQ) ? pc_q : '0;

      if (state_q == S_IDLE) begin
         ifid_wr_en = 1'b0;
         ifid_flush = 1'b0;
      end else if (redirect) begin
         ifid_wr_en = 1'b1;
         ifid_flush = 1'b1;
      end else if (stall) begin
         ifid_wr_en = 1'b0;
         ifid_flush = 1'b0;
      end else if (deliver) begin
         ifid_wr_en = 1'b1;
         ifid_flush = 1'b0;
      end else begin
         ifid_wr_en = 1'b1;
         ifid_flush = 1'b1;
      end

      ifid_instr   = deliver ? deliver_word : NOP_INSTR;
      ifid_pc_next = deliver ? pc_inc : '0;
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a behavioural instruction memory plus a
// transaction-level model of the fetch stream checked every cycle.
module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, redirect;
   logic [31:0] redirect_pc;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        ifid_wr_en, ifid_flush;
   logic [31:0] ifid_instr, ifid_pc_next;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // model of the fetch stream
   bit          m_started;
   bit          m_inflight;
   bit          m_useful;
   logic [31:0] m_pc;
   logic [31:0] m_held[$];

   // behavioural memory
   bit          mem_busy;
   int unsigned mem_cnt;
   logic [31:0] mem_addr;
   int unsigned lat_min, lat_max, ready_pct;

   always #5 clk = ~clk;

   if_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .ifid_wr_en     (ifid_wr_en),
      .ifid_flush     (ifid_flush),
      .ifid_instr     (ifid_instr),
      .ifid_pc_next   (ifid_pc_next)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
   endfunction

   function automatic bit rsp_now();
      return mem_busy && mem_cnt == 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_started  = 0;
      m_inflight = 0;
      m_useful   = 0;
      m_pc       = RST_PC;
      m_held.delete();
      mem_busy   = 0;
      mem_cnt    = 0;
      mem_addr   = '0;
   endtask

   // One cycle: drive inputs after the falling edge, check, advance model.
   task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
      logic        rdy, m_req, dlv, exp_we, exp_fl;
      logic [31:0] word, tgt;
      rdy            = ($urandom_range(99) < ready_pct);
      stall          = st;
      redirect       = rd;
      redirect_pc    = rpc;
      imem_req_ready = rdy;
      imem_rsp_valid = rsp_now();
      imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : $urandom;
      #1;
      tgt   = rpc & 32'hFFFF_FFFC;
      dlv   = 1'b0;
      word  = '0;
      m_req = m_started && !m_inflight && m_held.size() == 0;
      if (m_started) begin
         if (m_held.size() != 0) begin
            word = m_held[0];
            dlv  = !st && !rd;
         end else if (m_inflight && imem_rsp_valid) begin
            word = imem_rsp_data;
            dlv  = m_useful && !st && !rd;
         end
      end
      if (!m_started)  begin exp_we = 0; exp_fl = 0; end
      else if (rd)     begin exp_we = 1; exp_fl = 1; end
      else if (st)     begin exp_we = 0; exp_fl = 0; end
      else if (dlv)    begin exp_we = 1; exp_fl = 0; end
      else             begin exp_we = 1; exp_fl = 1; end

      chk("req_valid", 32'(imem_req_valid), 32'(m_req));
      chk("imem_addr", imem_addr, m_req ? m_pc : 32'h0);
      chk("wr_en",     32'(ifid_wr_en), 32'(exp_we));
      chk("flush",     32'(ifid_flush), 32'(exp_fl));
      chk("instr",     ifid_instr, dlv ? word : 32'h0);
      chk("pc_next",   ifid_pc_next, dlv ? 32'(m_pc + 32'd4) : 32'h0);

      if (!m_started) begin
         m_started = 1;
      end else if (m_held.size() != 0) begin
         if (rd) begin
            m_held.delete();
            m_pc = tgt;
         end else if (!st) begin
            m_held.delete();
            m_pc = 32'(m_pc + 32'd4);
         end
      end else if (m_inflight) begin
         if (imem_rsp_valid) begin
            m_inflight = 0;
            if (rd) m_pc = tgt;
            else if (m_useful) begin
               if (st) m_held.push_back(word);
               else    m_pc = 32'(m_pc + 32'd4);
            end
         end else if (rd) begin
            m_pc     = tgt;
            m_useful = 0;
         end
      end else begin
         if (rd) m_pc = tgt;
         if (rdy) begin
            m_inflight = 1;
            m_useful   = !rd;
         end
      end

      if (imem_rsp_valid) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (imem_req_valid && rdy) begin
         mem_busy = 1;
         mem_cnt  = $urandom_range(lat_max, lat_min);
         mem_addr = imem_addr;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset          = 1'b0;
      stall          = 1'b0;
      redirect       = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      ready_pct      = 100;
      lat_min        = 1;
      lat_max        = 1;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // back-to-back fetches with single-cycle memory
      repeat (8) step(0, 0, 32'h0);

      // longer latency produces bubbles between deliveries
      lat_min = 3; lat_max = 3;
      repeat (10) step(0, 0, 32'h0);

      // stall across an arriving response
      for (int i = 0; i < 20 && !rsp_now(); i++) step(0, 0, 32'h0);
      chk("tmo_rsp_stall", 32'(rsp_now()), 32'h1);
      repeat (4) step(1, 0, 32'h0);
      repeat (4) step(0, 0, 32'h0);

      // redirect while a request is outstanding
      for (int i = 0; i < 20 && !(mem_busy && mem_cnt > 1); i++) step(0, 0, 32'h0);
      chk("tmo_wait", 32'(mem_busy && mem_cnt > 1), 32'h1);
      step(0, 1, 32'h0000_0103);
      for (int i = 0; i < 20 && !imem_req_valid; i++) step(0, 0, 32'h0);
      chk("redir_addr", imem_addr, 32'h0000_0100);
      repeat (6) step(0, 0, 32'h0);

      // redirect coincident with response under stall
      for (int i = 0; i < 20 && !rsp_now(); i++) step(0, 0, 32'h0);
      chk("tmo_rsp_redir", 32'(rsp_now()), 32'h1);
      step(1, 1, 32'h0000_0203);
      repeat (6) step(0, 0, 32'h0);

      // fetch at the top of the address space wraps pc_next
      lat_min = 1; lat_max = 1;
      for (int i = 0; i < 20 && !imem_req_valid; i++) step(0, 0, 32'h0);
      step(0, 1, 32'hFFFF_FFFE);
      repeat (8) step(0, 0, 32'h0);

      // asynchronous reset while waiting for a response
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 20 && !(mem_busy && mem_cnt > 1); i++) step(0, 0, 32'h0);
      chk("tmo_wait_rst", 32'(mem_busy && mem_cnt > 1), 32'h1);
      stall    = 1'b0;
      redirect = 1'b0;
      #2 reset = 1'b0;
      imem_rsp_valid = 1'b0;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_addr",      imem_addr, 32'h0);
      chk("rst_wr_en",     32'(ifid_wr_en), 32'h0);
      chk("rst_flush",     32'(ifid_flush), 32'h0);
      chk("rst_instr",     ifid_instr, 32'h0);
      chk("rst_pc_next",   ifid_pc_next, 32'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (10) step(0, 0, 32'h0);

      // randomized traffic
      ready_pct = 70;
      lat_min   = 1;
      lat_max   = 4;
      for (int i = 0; i < 3000; i++) begin
         logic        st, rd;
         logic [31:0] rpc;
         st  = ($urandom % 4 == 0);
         rd  = ($urandom % 16 == 0);
         rpc = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
         step(st, rd, rpc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
IF-stage fetch engine that writes the IF/ID pipeline register.
- Owns the PC and issues one instruction-memory request at a time over a valid/ready request channel, accepting a valid-only response.
- Drives the IF/ID register inputs (write enable, flush, instruction, pc_next).
- Honours stall from the hazard unit and redirect from branch/jump resolution.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
stall  in  1  hazard unit: IF/ID must hold its contents this cycle
redirect  in  1  branch/jump taken; fetch restarts at redirect_pc
redirect_pc  in  32  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  32  fetch address (word aligned)
imem_rsp_valid  in  1  response data valid (one per accepted request, latency ≥1)
imem_rsp_data  in  32  fetched instruction
ifid_wr_en  out  1  IF/ID write enable
ifid_flush  out  1  IF/ID flush (IF/ID loads NOP, keeps pc_next)
ifid_instr  out  32  instruction to IF/ID
ifid_pc_next  out  32  PC+4 of delivered instruction

Behaviour:
- States: IDLE, REQ, WAIT, HOLD. Registers: pc, state, kill, hold_instr.
- Reset (reset=0, async):
  - state=IDLE, pc=RESET_PC, kill=0, hold_instr=0.
  - All outputs 0 while in IDLE.
- IDLE: unconditionally go to REQ next cycle. First request is issued in cycle 2 after reset release.
- REQ:
  - imem_req_valid=1, imem_addr=pc.
  - On ready: go to WAIT.
  - imem_addr is stable while valid&&!ready, except on redirect.
  - Redirect (accepted or not): pc<=redirect_pc&~3. If the request was accepted that cycle, set kill=1 and go to WAIT.
- WAIT (imem_req_valid=0):
  - rsp_valid with kill=1, or with redirect: discard the response, clear kill, pc<=redirect target (if redirect), go to REQ.
  - Redirect without rsp_valid: pc<=redirect_pc&~3, kill<=1.
  - rsp_valid, !kill, !redirect, !stall: deliver imem_rsp_data; pc<=pc+4; go to REQ.
  - rsp_valid, !kill, !redirect, stall: hold_instr<=imem_rsp_data; go to HOLD.
- HOLD:
  - !stall, !redirect: deliver hold_instr; pc<=pc+4; go to REQ.
  - Redirect: drop hold_instr; pc<=redirect_pc&~3; go to REQ.
- IF/ID drive, evaluated each cycle in priority order:
  1. Redirect: wr_en=1, flush=1 (squash wrong-path instruction), regardless of stall.
  2. Stall: wr_en=0, flush=0.
  3. Delivering: wr_en=1, flush=0, instr=delivered word, pc_next=pc+4.
  4. Otherwise (bubble): wr_en=1, flush=1.
  - In IDLE: wr_en=0.
- Width and alignment rules:
  - pc+4 wraps modulo 2^32.
  - redirect_pc[1:0] is ignored (forced 0).
- ifid_instr/ifid_pc_next are don't-care when not delivering; drive 0.
- Delay-slot policy belongs to the redirect source; this block only restarts at redirect_pc.
- Memory is reset by the same reset, so no response survives a reset. Reset mid-WAIT therefore needs no drain.
- At most one outstanding request. No new request is issued before its response returns.

Decomposition:
- Shared pipeline package:
  - fetch state encoding (IDLE/REQ/WAIT/HOLD)
  - NOP_INSTR=32'h0000_0000
  - PC_STEP=4
  - default RESET_PC
- No sub-module. PC incrementer and hold buffer are inline; the block is small enough for one FSM plus datapath.

Test Plan:
- Reset release, ready=1, 1-cycle latency, words A,B,C at 0,4,8 → imem_addr 0,4,8. Deliveries A/pc_next=4, B/8, C/12, each with wr_en=1, flush=0.
- Response latency 3 cycles → bubbles (wr_en=1, flush=1) in the 2 waiting cycles, then delivery; only one request outstanding.
- stall=1 for 4 cycles as a response arrives → HOLD, wr_en=0 throughout. On stall release, the held word is delivered once and the next fetch is at pc+4.
- redirect to 0x0000_0103 while WAIT outstanding → flush pulse that cycle; the late response is discarded; the next imem_addr is 0x0000_0100.
- redirect and rsp_valid in the same cycle, with stall=1 → redirect wins: wr_en=1, flush=1, response dropped, next request at the target.
- pc=0xFFFF_FFFC fetch delivered → ifid_pc_next=0, next imem_addr=0. Async reset asserted mid-WAIT → outputs 0 immediately; fetch restarts at RESET_PC.
